// File: rtl/shifter_pkg.sv
// Shared constants and state encoding for the sequenced shifter.
package shifter_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int CNT_W  = 3;

  localparam logic SH_LEFT  = 1'b0;
  localparam logic SH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;
endpackage

// File: rtl/shift_stage_unit.sv
// One binary stage of the barrel: shift by 2**idx, or pass through when disabled.
module shift_stage_unit
  import shifter_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             dir,
  input  logic [CNT_W-1:0] idx,
  input  logic             en,
  input  logic [W-1:0]     d_in,
  output logic [W-1:0]     d_out
);
  logic [W-1:0] shl;
  logic [W-1:0] sar;

  // Sign fill comes from the current MSB, which always holds the captured sign bit.
  always_comb begin
    shl   = d_in << (1 << idx);
    sar   = W'($signed(d_in) >>> (1 << idx));
    d_out = d_in;
    if (en) d_out = (dir == SH_RIGHT) ? sar : shl;
  end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one shared stage walked through 16,8,4,2,1, one per clock.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = AMT_W
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          SH_DIR,
  input  logic [AW-1:0] SH_AMT,
  input  logic [DW-1:0] D_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] D_OUT
);
  state_e           state_q, state_d;
  logic [DW-1:0]    work_q,  work_d;
  logic [AW-1:0]    amt_q,   amt_d;
  logic             dir_q,   dir_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [DW-1:0]    dout_q,  dout_d;

  // Zero-extend the amount so any counter value indexes a real bit.
  logic [(2**CNT_W)-1:0] amt_ext;
  logic [DW-1:0]         stage_out;

  assign amt_ext = {{((2**CNT_W)-AW){1'b0}}, amt_q};

  shift_stage_unit #(.W(DW)) u_stage (
    .dir   (dir_q),
    .idx   (cnt_q),
    .en    (amt_ext[cnt_q]),
    .d_in  (work_q),
    .d_out (stage_out)
  );

  // Next-state: accept in IDLE or FIN, step the stage counter in SHIFT.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          work_d  = D_IN;
          amt_d   = SH_AMT;
          dir_d   = SH_DIR;
          cnt_d   = CNT_W'(AW - 1);
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        work_d = stage_out;
        if (cnt_q == '0) begin
          dout_d  = stage_out;
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any running operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      dir_q   <= SH_LEFT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign D_OUT = dout_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against a one-step shift model.
module tb_shift_sequencer;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        SH_DIR;
  logic [4:0]  SH_AMT;
  logic [31:0] D_IN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] D_OUT;

  int tests = 0;
  int fails = 0;

  shift_sequencer dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .SH_DIR (SH_DIR),
    .SH_AMT (SH_AMT),
    .D_IN   (D_IN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .D_OUT  (D_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference: a single whole-amount shift.
  function automatic logic [31:0] model(logic dir, logic [4:0] amt, logic [31:0] d);
    if (dir) return 32'($signed(d) >>> amt);
    return d << amt;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from idle and check BUSY/DONE timing and result.
  // inject: raise START with other operands two cycles in, while busy.
  task automatic run_op(string tag, logic dir, logic [4:0] amt, logic [31:0] d,
                        logic [31:0] exp, bit inject);
    logic [31:0] prev;
    @(negedge CLK);
    prev = D_OUT;
    START = 1'b1; SH_DIR = dir; SH_AMT = amt; D_IN = d;
    @(posedge CLK); #1;
    START = 1'b0;
    D_IN  = $urandom;
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      if (inject && k == 1) begin
        START = 1'b1; SH_DIR = 1'b1; SH_AMT = 5'd4; D_IN = 32'hFFFF0000;
      end
      if (inject && k == 2) START = 1'b0;
      if (k < 5) begin
        chk({tag, ".busy"}, {31'b0, BUSY}, 32'd1);
        chk({tag, ".nodone"}, {31'b0, DONE}, 32'd0);
        chk({tag, ".hold"}, D_OUT, prev);
      end else begin
        chk({tag, ".done"}, {31'b0, DONE}, 32'd1);
        chk({tag, ".busy_lo"}, {31'b0, BUSY}, 32'd0);
        chk({tag, ".dout"}, D_OUT, exp);
      end
    end
    @(negedge CLK);
    chk({tag, ".pulse"}, {31'b0, DONE}, 32'd0);
    chk({tag, ".idle"}, {31'b0, BUSY}, 32'd0);
    chk({tag, ".keep"}, D_OUT, exp);
    if (inject) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        chk({tag, ".no2nd"}, {31'b0, DONE | BUSY}, 32'd0);
      end
    end
  endtask

  initial begin
    logic        dir;
    logic [4:0]  amt;
    logic [31:0] d, exp, prev;
    int          cyc;

    RST_N = 1'b0; START = 1'b0; SH_DIR = 1'b0; SH_AMT = '0; D_IN = '0;
    #1;
    chk("rst.busy", {31'b0, BUSY}, 32'd0);
    chk("rst.done", {31'b0, DONE}, 32'd0);
    chk("rst.dout", D_OUT, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    run_op("l8",    1'b0, 5'd8,  32'h000000FF, 32'h0000FF00, 1'b0);
    run_op("r31n",  1'b1, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("r31p",  1'b1, 5'd31, 32'h7FFFFFFF, 32'h00000000, 1'b0);
    run_op("r4",    1'b1, 5'd4,  32'hF0000000, 32'hFF000000, 1'b0);
    run_op("l0",    1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    run_op("r0",    1'b1, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    run_op("l31",   1'b0, 5'd31, 32'h00000003, 32'h80000000, 1'b0);
    run_op("ignore",1'b0, 5'd1,  32'h00000001, 32'h00000002, 1'b1);

    // Reset in the third SHIFT cycle aborts with no DONE.
    @(negedge CLK);
    START = 1'b1; SH_DIR = 1'b0; SH_AMT = 5'd3; D_IN = 32'h12345678;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("abort.busy", {31'b0, BUSY}, 32'd0);
    chk("abort.done", {31'b0, DONE}, 32'd0);
    chk("abort.dout", D_OUT, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("abort.nodone", {31'b0, DONE}, 32'd0);
    end
    run_op("postrst", 1'b0, 5'd16, 32'h0000ABCD, 32'hABCD0000, 1'b0);

    // START held high: back-to-back issue, DONE every 6 cycles.
    @(negedge CLK);
    dir = 1'($urandom); amt = 5'($urandom); d = $urandom;
    exp = model(dir, amt, d);
    prev = D_OUT;
    START = 1'b1; SH_DIR = dir; SH_AMT = amt; D_IN = d;
    @(posedge CLK);
    for (int op = 0; op < 24; op++) begin
      cyc = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge CLK);
        cyc++;
        if (DONE) break;
        chk("b2b.hold", D_OUT, prev);
        if (k == 2) begin
          SH_DIR = ~SH_DIR; SH_AMT = 5'($urandom); D_IN = $urandom;
        end
      end
      chk("b2b.period", cyc, 6);
      chk("b2b.done", {31'b0, DONE}, 32'd1);
      chk("b2b.dout", D_OUT, exp);
      prev = D_OUT;
      dir = 1'($urandom); amt = 5'($urandom); d = $urandom;
      if (op % 5 == 0) amt = (op % 2 == 0) ? 5'd0 : 5'd31;
      exp = model(dir, amt, d);
      SH_DIR = dir; SH_AMT = amt; D_IN = d;
      if (op == 23) START = 1'b0;
      @(posedge CLK);
    end
    @(negedge CLK);
    chk("b2b.end_done", {31'b0, DONE}, 32'd0);
    chk("b2b.end_busy", {31'b0, BUSY}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
